// File: rtl/trim_pkg.sv
// Shared types and constants for the bandgap trim SAR sequencer.
// Also used by benches and the manual-load path.
package trim_pkg;

  localparam int unsigned CODE_W = 12;

  localparam logic [CODE_W-1:0] TRIM_NOMINAL = 12'h7BF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_SETTLE,
    ST_SAMPLE,
    ST_NEXT,
    ST_FINISH,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/trim_tick_gen.sv
// Free-running timing tick divider, one-cycle tick every CLK_DIV clocks.
// Shared with the trim shifter's serial clock divider.
module trim_tick_gen #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic CLOCK_50,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST)
      cnt_q <= '0;
    else if (clr || tick)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + W'(1);
  end

endmodule

// File: rtl/trim_sar_ctrl.sv
// Successive-approximation search for the bandgap trim code,
// driving the serial trim shifter through its load handshake.
module trim_sar_ctrl
  import trim_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned SETTLE_TICKS = 8,
  parameter int unsigned LOAD_TIMEOUT = 64
) (
  input  logic              CLOCK_50,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic              CMP,
  input  logic              LOAD_DONE,
  output logic              LOAD_REQ,
  output logic [CODE_W-1:0] LOAD_CODE,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [CODE_W-1:0] TRIM_OUT,
  output logic [3:0]        BIT_IDX
);

  localparam int unsigned CMAX =
    (SETTLE_TICKS > LOAD_TIMEOUT) ? SETTLE_TICKS : LOAD_TIMEOUT;
  localparam int unsigned CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_TICKS - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOAD_TIMEOUT - 1);
  localparam logic [CODE_W-1:0] MSB_CODE = {1'b1, {(CODE_W-1){1'b0}}};

  state_t state_q;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] trim_q;
  logic [3:0] bit_q;
  logic [CW-1:0] cnt_q;
  logic fin_q;
  logic req_q;
  logic busy_q;
  logic done_q;
  logic err_q;

  logic [1:0] start_sq;
  logic [1:0] abort_sq;
  logic [1:0] cmp_sq;
  logic start_pq;

  logic start_rise;
  logic abort_s;
  logic cmp_s;
  logic tick;
  logic tick_clr;

  assign start_rise = start_sq[1] & ~start_pq;
  assign abort_s = abort_sq[1];
  assign cmp_s = cmp_sq[1];
  assign tick_clr = (state_q == ST_LOAD) && LOAD_DONE;

  trim_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .CLOCK_50(CLOCK_50),
    .RST(RST),
    .clr(tick_clr),
    .tick(tick)
  );

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      start_sq <= '0;
      abort_sq <= '0;
      cmp_sq <= '0;
      start_pq <= 1'b0;
    end else begin
      start_sq <= {start_sq[0], START};
      abort_sq <= {abort_sq[0], ABORT};
      cmp_sq <= {cmp_sq[0], CMP};
      start_pq <= start_sq[1];
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      code_q <= '0;
      trim_q <= '0;
      bit_q <= '0;
      cnt_q <= '0;
      fin_q <= 1'b0;
      req_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (start_rise) begin
            state_q <= ST_SETUP;
            err_q <= 1'b0;
            busy_q <= 1'b1;
            bit_q <= 4'(CODE_W - 1);
            code_q <= MSB_CODE;
            fin_q <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (abort_s) begin
            state_q <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            req_q <= 1'b1;
            cnt_q <= '0;
            state_q <= ST_LOAD;
          end
        end
        // Abort is only honoured at frame end so the shifter is never cut.
        ST_LOAD: begin
          if (LOAD_DONE) begin
            req_q <= 1'b0;
            cnt_q <= '0;
            if (abort_s) begin
              state_q <= ST_IDLE;
              busy_q <= 1'b0;
            end else if (fin_q) begin
              state_q <= ST_FINISH;
              trim_q <= code_q;
              done_q <= 1'b1;
            end else begin
              state_q <= ST_SETTLE;
            end
          end else if (tick) begin
            if (cnt_q == TO_LAST) begin
              state_q <= ST_ERROR;
              err_q <= 1'b1;
              busy_q <= 1'b0;
              req_q <= 1'b0;
            end else if (cnt_q != '1) begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ST_SETTLE: begin
          if (abort_s) begin
            state_q <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (tick) begin
            if (cnt_q == SET_LAST)
              state_q <= ST_SAMPLE;
            else if (cnt_q != '1)
              cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_SAMPLE: begin
          if (abort_s) begin
            state_q <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            if (cmp_s)
              code_q[bit_q] <= 1'b0;
            state_q <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (abort_s) begin
            state_q <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            if (bit_q == 4'd0) begin
              fin_q <= 1'b1;
            end else begin
              bit_q <= bit_q - 4'd1;
              code_q[bit_q - 4'd1] <= 1'b1;
            end
            req_q <= 1'b1;
            cnt_q <= '0;
            state_q <= ST_LOAD;
          end
        end
        ST_FINISH: begin
          busy_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign LOAD_REQ = req_q;
  assign LOAD_CODE = code_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR = err_q;
  assign TRIM_OUT = trim_q;
  assign BIT_IDX = bit_q;

endmodule
